// File: rtl/sum_if_pkg.sv
// Shared types and constants for the sum_if_stimulus initiator and its LFSR.
package sum_if_pkg;

    // Run controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sum_stim_state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback taps on bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

    // Widest operand the expected-value pipeline carries; operands are zero-extended into it.
    localparam int VEC_MAX_W = 8;

    // One expected-pipeline stage: issued operands and their full-width sum.
    typedef struct packed {
        logic                 valid;
        logic [VEC_MAX_W-1:0] a;
        logic [VEC_MAX_W-1:0] b;
        logic [VEC_MAX_W:0]   exp;
    } sum_stim_vec_t;

    // Fibonacci step, shifting left; the feedback bit enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sum_stim_lfsr.sv
// 8-bit pseudo-random source: load restores the seed, step advances one state.
module sum_stim_lfsr
    import sum_if_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q, lfsr_d;

    // Load has priority over step so a restart always begins at the seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/sum_if_stimulus.sv
// Self-checking initiator for a registered adder: drives a/b, pipelines the
// expected sum alongside the responder latency and counts mismatches on c.
// Handshake: none; one vector is issued every cycle in DRIVE and the responder
// must present its sum exactly LATENCY edges after it samples the operands.
module sum_if_stimulus
    import sum_if_pkg::*;
#(
    parameter int         W         = 2,
    parameter int         LATENCY   = 1,
    parameter logic [7:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [15:0]     num_vectors,
    output logic [W-1:0]    a_o,
    output logic [W-1:0]    b_o,
    input  logic [W:0]      c_i,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_count,
    output logic [W-1:0]    first_err_a,
    output logic [W-1:0]    first_err_b,
    output logic [W:0]      first_err_c,
    output sum_stim_state_t state_o
);

    localparam int VW = 2 * W;
    localparam int EW = VEC_MAX_W + 1;

    sum_stim_state_t state_q, state_d;
    logic            mode_q, mode_d;
    logic [15:0]     nv_q, nv_d;
    logic [15:0]     idx_q, idx_d;
    logic [15:0]     err_q, err_d;
    logic [W-1:0]    fea_q, fea_d, feb_q, feb_d;
    logic [W:0]      fec_q, fec_d;
    sum_stim_vec_t   pipe_q [1:LATENCY];
    sum_stim_vec_t   vec_in, vec_out;
    logic [7:0]      lfsr_val;
    logic [VW-1:0]   stim;
    logic            start_ok, driving, pipe_busy, mismatch;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign driving  = (state_q == ST_DRIVE);

    sum_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .step_i  (driving),
        .value_o (lfsr_val)
    );

    // Current vector: sweep index or LFSR bits; operands idle at zero outside DRIVE.
    always_comb begin
        stim = mode_q ? VW'(lfsr_val) : idx_q[VW-1:0];
        a_o  = driving ? stim[VW-1:W] : '0;
        b_o  = driving ? stim[W-1:0]  : '0;
    end

    // Stage entering the expected pipeline; only DRIVE vectors are marked valid.
    always_comb begin
        vec_in.valid = driving;
        vec_in.a     = VEC_MAX_W'(a_o);
        vec_in.b     = VEC_MAX_W'(b_o);
        vec_in.exp   = EW'(a_o) + EW'(b_o);
    end

    assign vec_out  = pipe_q[LATENCY];
    assign mismatch = vec_out.valid && (vec_out.exp != EW'(c_i));

    // Any vector still in flight other than the one compared at this edge.
    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_busy = pipe_busy | pipe_q[k].valid;
        end
    end

    // Next-state logic for the run controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = (num_vectors == 16'd0) ? ST_DONE : ST_DRIVE;
            end
            ST_DRIVE: begin
                if (idx_q == nv_q - 16'd1) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run parameters, vector index and result bookkeeping.
    always_comb begin
        mode_d = mode_q;
        nv_d   = nv_q;
        idx_d  = idx_q;
        err_d  = err_q;
        fea_d  = fea_q;
        feb_d  = feb_q;
        fec_d  = fec_q;
        if (start_ok) begin
            mode_d = mode;
            nv_d   = num_vectors;
            idx_d  = '0;
            err_d  = '0;
            fea_d  = '0;
            feb_d  = '0;
            fec_d  = '0;
        end else begin
            if (driving) idx_d = idx_q + 16'd1;
            if (mismatch) begin
                if (err_q == 16'd0) begin
                    fea_d = vec_out.a[W-1:0];
                    feb_d = vec_out.b[W-1:0];
                    fec_d = c_i;
                end
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
        end
    end

    // Controller and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            nv_q    <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            fea_q   <= '0;
            feb_q   <= '0;
            fec_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nv_q    <= nv_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
            fec_q   <= fec_d;
        end
    end

    // Expected-value pipeline, aligned to the responder latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[1] <= vec_in;
            for (int k = 2; k <= LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign busy        = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign err_count   = err_q;
    assign first_err_a = fea_q;
    assign first_err_b = feb_q;
    assign first_err_c = fec_q;
    assign state_o     = state_q;

endmodule
